// File: rtl/xilly_hub_pkg.sv
// Shared types and helpers for the Xillybus stream hub.
package xilly_hub_pkg;

  localparam int unsigned XILLY_W = 32;

  typedef logic [XILLY_W-1:0] xilly_word_t;

  // Smallest w such that 2**w >= depth; sizes FIFO pointers.
  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
// A push while full is dropped; a pop at full still proceeds.
module sync_fifo
  import xilly_hub_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = XILLY_W,
  localparam int unsigned AW = clog2_depth(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push & ~w_full;
  assign w_pop   = (r_count != '0) & i_ready;
  assign o_full  = w_full;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; contents are don't-care once pointers are reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/xillybus_stream_hub.sv
// User-side stream hub: N_WR buffered host-to-FPGA channels with close
// tracking, and one buffered FPGA-to-host channel with length-based EOF.
// Optional statistics counters are enabled by defining XILLY_HUB_STATS_EN.
module xillybus_stream_hub
  import xilly_hub_pkg::*;
#(
  parameter int unsigned N_WR       = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                      bus_clk,
  input  logic                      bus_rst,
  input  logic [N_WR-1:0]           user_w_wren,
  input  logic [XILLY_W*N_WR-1:0]   user_w_data,
  input  logic [N_WR-1:0]           user_w_open,
  output logic [N_WR-1:0]           user_w_full,
  output logic [N_WR-1:0]           wr_out_valid,
  input  logic [N_WR-1:0]           wr_out_ready,
  output logic [XILLY_W*N_WR-1:0]   wr_out_data,
  output logic [N_WR-1:0]           wr_out_last,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  xilly_word_t               res_data,
  input  logic [LEN_W-1:0]          rd_len,
  input  logic                      user_r_rden,
  input  logic                      user_r_open,
  output logic                      user_r_empty,
  output xilly_word_t               user_r_data,
  output logic                      user_r_eof
`ifdef XILLY_HUB_STATS_EN
  ,
  output logic [XILLY_W*N_WR-1:0]   stat_wr_words,
  output logic [XILLY_W*N_WR-1:0]   stat_wr_drops,
  output logic [XILLY_W-1:0]        stat_rd_words
`endif
);

  localparam int unsigned CW = clog2_depth(FIFO_DEPTH) + 1;

  for (genvar k = 0; k < N_WR; k++) begin : g_wr
    logic [CW-1:0] w_count;
    logic          w_valid;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_last;
    logic          w_left;
    logic          r_open_q;
    logic          r_closing;

    sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (XILLY_W)
    ) u_fifo (
      .i_clk   (bus_clk),
      .i_rst   (bus_rst),
      .i_push  (user_w_wren[k]),
      .i_data  (user_w_data[XILLY_W*k +: XILLY_W]),
      .o_full  (user_w_full[k]),
      .i_ready (wr_out_ready[k]),
      .o_data  (wr_out_data[XILLY_W*k +: XILLY_W]),
      .o_count (w_count)
    );

    assign w_valid   = (w_count != '0);
    assign w_push_ok = user_w_wren[k] & ~user_w_full[k];
    assign w_pop_ok  = w_valid & wr_out_ready[k];
    assign w_last    = r_closing & w_valid & (w_count == CW'(1));
    // FIFO still holds something after this cycle's push/pop.
    assign w_left    = (w_count > CW'(1)) | w_push_ok | ((w_count == CW'(1)) & ~w_pop_ok);

    assign wr_out_valid[k] = w_valid;
    assign wr_out_last[k]  = w_last;

    // Closing flag: armed on open falling (only if words remain), cleared by
    // the flagged pop or by the file reopening.
    always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
        r_open_q  <= 1'b0;
        r_closing <= 1'b0;
      end else begin
        r_open_q <= user_w_open[k];
        if (~r_open_q & user_w_open[k]) begin
          r_closing <= 1'b0;
        end else if (r_open_q & ~user_w_open[k]) begin
          r_closing <= w_left;
        end else if (w_last & w_pop_ok) begin
          r_closing <= 1'b0;
        end
      end
    end

`ifdef XILLY_HUB_STATS_EN
    logic [XILLY_W-1:0] r_wr_words;
    logic [XILLY_W-1:0] r_wr_drops;

    // Per-channel accepted and dropped write counters, wrapping.
    always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
        r_wr_words <= '0;
        r_wr_drops <= '0;
      end else begin
        if (w_push_ok) r_wr_words <= r_wr_words + 32'd1;
        if (user_w_wren[k] & user_w_full[k]) r_wr_drops <= r_wr_drops + 32'd1;
      end
    end

    assign stat_wr_words[XILLY_W*k +: XILLY_W] = r_wr_words;
    assign stat_wr_drops[XILLY_W*k +: XILLY_W] = r_wr_drops;
`endif
  end

  // Read side
  logic [CW-1:0] w_rd_count;
  logic          w_rd_full;
  xilly_word_t   w_rd_dout;
  logic          w_rd_valid;
  logic          w_eof_now;
  logic          w_eof;
  logic          w_rd_avail;
  logic          w_rd_pop;
  logic          w_r_fall;
  logic [LEN_W-1:0] r_rd_cnt;
  logic          r_eof;
  logic          r_r_open_q;
  xilly_word_t   r_rd_data;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XILLY_W)
  ) u_rd_fifo (
    .i_clk   (bus_clk),
    .i_rst   (bus_rst),
    .i_push  (res_valid),
    .i_data  (res_data),
    .o_full  (w_rd_full),
    .i_ready (w_rd_pop),
    .o_data  (w_rd_dout),
    .o_count (w_rd_count)
  );

  assign w_rd_valid = (w_rd_count != '0);
  assign w_eof_now  = (rd_len != '0) & (r_rd_cnt == rd_len) & ~w_rd_valid;
  assign w_eof      = r_eof | w_eof_now;
  // Words arriving after EOF stay hidden until the file is reopened.
  assign w_rd_avail = w_rd_valid & ~w_eof;
  assign w_rd_pop   = user_r_rden & w_rd_avail;
  assign w_r_fall   = r_r_open_q & ~user_r_open;

  assign res_ready    = ~w_rd_full;
  assign user_r_empty = ~w_rd_avail;
  assign user_r_data  = r_rd_data;
  assign user_r_eof   = w_eof;

  // Read data register, saturating pop counter and sticky EOF.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      r_rd_data  <= '0;
      r_rd_cnt   <= '0;
      r_eof      <= 1'b0;
      r_r_open_q <= 1'b0;
    end else begin
      r_r_open_q <= user_r_open;
      if (w_rd_pop) r_rd_data <= w_rd_dout;
      if (w_r_fall) begin
        r_rd_cnt <= '0;
        r_eof    <= 1'b0;
      end else begin
        if (w_rd_pop && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + LEN_W'(1);
        r_eof <= w_eof;
      end
    end
  end

`ifdef XILLY_HUB_STATS_EN
  logic [XILLY_W-1:0] r_rd_words;

  // Host read pop counter, wrapping.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) r_rd_words <= '0;
    else if (w_rd_pop) r_rd_words <= r_rd_words + 32'd1;
  end

  assign stat_rd_words = r_rd_words;
`endif

endmodule
